// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one tinyalu between requesters
module alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_A,
    input  logic [8*N_REQ-1:0]   req_B,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [7:0]           alu_A,
    output logic [7:0]           alu_B,
    output logic [2:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_next;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic [7:0]        sel_a;
    logic [7:0]        sel_b;
    logic [2:0]        sel_op;
    logic [7:0]        lat_a;
    logic [7:0]        lat_b;
    logic [2:0]        lat_op;
    logic [ID_W-1:0]   lat_id;
    logic [15:0]       res;
    logic              err;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
    int                j;

    // Round-robin search: first valid requester at or above the pointer, wrapping at N_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        ptr_next    = ptr;
        sel_a       = 8'h00;
        sel_b       = 8'h00;
        sel_op      = 3'b000;
        j           = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(j);
                ptr_next    = (j + 1 == N_REQ) ? '0 : ID_W'(j + 1);
                sel_a       = req_A[j*8 +: 8];
                sel_b       = req_B[j*8 +: 8];
                sel_op      = req_op[j*3 +: 3];
            end
        end
    end

    assign timeout_hit = ((cnt + 1'b1) == CNT_W'(TIMEOUT));

    // State register; reset drops alu_start immediately because outputs decode the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and output generation; response fields are zero outside RESP
    always_comb begin
        state_next = state;
        req_ready  = '0;
        alu_start  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_result = 16'h0000;
        rsp_err    = 1'b0;
        alu_A      = lat_a;
        alu_B      = lat_b;
        alu_op     = lat_op;
        case (state)
            IDLE: begin
                if (grant_found && reset_n) begin
                    req_ready  = N_REQ'(1) << grant_id;
                end
                if (grant_found) begin
                    state_next = (sel_op == 3'b000) ? RESP : BUSY;
                end
            end
            BUSY: begin
                alu_start = 1'b1;
                if (alu_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_id     = lat_id;
                rsp_result = res;
                rsp_err    = err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, pointer advance, BUSY cycle counter and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= '0;
            lat_a  <= 8'h00;
            lat_b  <= 8'h00;
            lat_op <= 3'b000;
            lat_id <= '0;
            res    <= 16'h0000;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_found) begin
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_op <= sel_op[2] ? 3'b100 : sel_op;
                        lat_id <= grant_id;
                        ptr    <= ptr_next;
                        res    <= 16'h0000;
                        err    <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (alu_done) begin
                        res <= alu_result;
                        err <= 1'b0;
                    end else if (timeout_hit) begin
                        res <= 16'h0000;
                        err <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
